// File: rtl/filter_reduce_accum_unit_if.sv
// Trace-side and config-bus signals of the filter/reduce/accumulate stage.
// The upstream driver uses the master modport; the stage itself uses slave.
interface filter_reduce_accum_unit_if #(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CHAIN_W    = 2
);
    logic                              tracing;
    logic                              valid_in;
    logic                              eof_in;
    logic                              bof_in;
    logic [CHAIN_W-1:0]                chainId_in;
    logic [7:0]                        configId;
    logic [7:0]                        configData;
    logic [N-1:0][DATA_WIDTH-1:0]      vector_in;
    logic [N-1:0][DATA_WIDTH-1:0]      vector_out;
    logic [CHAIN_W-1:0]                chainId_out;
    logic                              valid_out;
    logic                              eof_out;
    logic                              bof_out;
    logic                              overflow_out;

    modport master (
        output tracing, valid_in, eof_in, bof_in, chainId_in, configId, configData, vector_in,
        input  vector_out, chainId_out, valid_out, eof_out, bof_out, overflow_out
    );

    modport slave (
        input  tracing, valid_in, eof_in, bof_in, chainId_in, configId, configData, vector_in,
        output vector_out, chainId_out, valid_out, eof_out, bof_out, overflow_out
    );
endinterface

// File: rtl/filter_reduce_accum_unit.sv
// Bins each input vector against M+1 loadable bounds, reduces the match matrix per bin or
// per element, and per chain forwards the vector, forwards counts, or builds a frame histogram.
module filter_reduce_accum_unit #(
    parameter int unsigned            N                  = 8,
    parameter int unsigned            M                  = 8,
    parameter int unsigned            DATA_WIDTH         = 32,
    parameter int unsigned            ACC_WIDTH          = 16,
    parameter int unsigned            MAX_CHAINS         = 4,
    parameter logic [7:0]             PERSONAL_CONFIG_ID = 8'd0,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_MODE      = '0,
    parameter logic [MAX_CHAINS-1:0]  INITIAL_AXIS       = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    filter_reduce_accum_unit_if.slave   bus
);
    localparam int unsigned CW        = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
    localparam int unsigned BPB       = DATA_WIDTH / 8;
    localparam int unsigned CFG_BYTES = 2 * MAX_CHAINS + (M + 1) * BPB;
    localparam int unsigned CFGW      = $clog2(CFG_BYTES + 1);
    localparam int unsigned CNTW      = $clog2(N + 1);
    localparam int unsigned AW1       = ACC_WIDTH + 1;
    localparam logic [AW1-1:0] ACC_MAX = {1'b0, {ACC_WIDTH{1'b1}}};

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ACC_WIDTH-1:0]  acc_t;

    logic [MAX_CHAINS-1:0][7:0]        mode_q, mode_d;
    logic [MAX_CHAINS-1:0]             axis_q, axis_d;
    word_t [M:0]                       bound_q, bound_d;
    logic [CFGW-1:0]                   cfg_cnt_q, cfg_cnt_d;

    logic                              s1_valid_q, s1_valid_d;
    word_t [N-1:0]                     s1_vec_q, s1_vec_d;
    logic [CW-1:0]                     s1_chain_q, s1_chain_d;
    logic [7:0]                        s1_mode_q, s1_mode_d;
    logic                              s1_axis_q, s1_axis_d;
    logic                              s1_bof_q, s1_bof_d;
    logic                              s1_eof_q, s1_eof_d;

    acc_t [MAX_CHAINS-1:0][N-1:0]      acc_q, acc_d;
    logic [MAX_CHAINS-1:0]             ovf_q, ovf_d;

    word_t [N-1:0]                     vector_out_q, vector_out_d;
    logic [CW-1:0]                     chain_out_q, chain_out_d;
    logic                              valid_out_q, valid_out_d;
    logic                              eof_out_q, eof_out_d;
    logic                              bof_out_q, bof_out_d;
    logic                              ovf_out_q, ovf_out_d;

    logic [N-1:0][M-1:0]               hit;
    logic [N-1:0][CNTW-1:0]            cnt;
    logic [N-1:0][AW1-1:0]             sum;
    acc_t [N-1:0]                      acc_new;
    logic                              sat_any;

    // Config byte stream: modes, then axes, then bounds shifted in MSB byte first.
    always_comb begin
        mode_d    = mode_q;
        axis_d    = axis_q;
        bound_d   = bound_q;
        cfg_cnt_d = '0;
        if (!bus.tracing && bus.configId == PERSONAL_CONFIG_ID) begin
            cfg_cnt_d = (cfg_cnt_q == CFGW'(CFG_BYTES)) ? cfg_cnt_q : cfg_cnt_q + CFGW'(1);
            for (int unsigned c = 0; c < MAX_CHAINS; c++) begin
                if (cfg_cnt_q == CFGW'(c))              mode_d[c] = bus.configData;
                if (cfg_cnt_q == CFGW'(MAX_CHAINS + c)) axis_d[c] = bus.configData[0];
            end
            for (int unsigned k = 0; k <= M; k++) begin
                if (cfg_cnt_q >= CFGW'(2 * MAX_CHAINS + k * BPB) &&
                    cfg_cnt_q <  CFGW'(2 * MAX_CHAINS + (k + 1) * BPB))
                    bound_d[k] = DATA_WIDTH'({bound_q[k], bus.configData});
            end
        end
    end

    // Stage 1 capture; the data side holds when nothing is accepted.
    always_comb begin
        s1_valid_d = bus.tracing & bus.valid_in;
        s1_vec_d   = s1_vec_q;
        s1_chain_d = s1_chain_q;
        s1_mode_d  = s1_mode_q;
        s1_axis_d  = s1_axis_q;
        s1_bof_d   = s1_bof_q;
        s1_eof_d   = s1_eof_q;
        if (s1_valid_d) begin
            s1_vec_d   = bus.vector_in;
            s1_chain_d = bus.chainId_in;
            s1_mode_d  = mode_q[bus.chainId_in];
            s1_axis_d  = axis_q[bus.chainId_in];
            s1_bof_d   = bus.bof_in;
            s1_eof_d   = bus.eof_in;
        end
    end

    // Bin match matrix and its reduction along the selected axis.
    always_comb begin
        hit = '0;
        cnt = '0;
        for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < M; j++)
                hit[i][j] = (s1_vec_q[i] > bound_q[j]) && (s1_vec_q[i] <= bound_q[j + 1]);
        for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < M; j++) begin
                if (s1_axis_q) cnt[i] = cnt[i] + CNTW'(hit[i][j]);
                else           cnt[j] = cnt[j] + CNTW'(hit[i][j]);
            end
    end

    // Stage 2: read-modify-write of the chain bank in one cycle keeps back-to-back updates exact.
    always_comb begin
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        sat_any      = 1'b0;
        vector_out_d = '0;
        chain_out_d  = '0;
        valid_out_d  = 1'b0;
        eof_out_d    = 1'b0;
        bof_out_d    = 1'b0;
        ovf_out_d    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i] = AW1'(s1_bof_q ? acc_t'(0) : acc_q[s1_chain_q][i]) + AW1'(cnt[i]);
            if (sum[i] > ACC_MAX) begin
                acc_new[i] = ACC_MAX[ACC_WIDTH-1:0];
                sat_any    = 1'b1;
            end else begin
                acc_new[i] = sum[i][ACC_WIDTH-1:0];
            end
        end
        if (s1_valid_q) begin
            chain_out_d = s1_chain_q;
            case (s1_mode_q)
                8'd1: begin
                    valid_out_d = 1'b1;
                    bof_out_d   = s1_bof_q;
                    eof_out_d   = s1_eof_q;
                    for (int unsigned i = 0; i < N; i++) vector_out_d[i] = DATA_WIDTH'(cnt[i]);
                end
                8'd2: begin
                    acc_d[s1_chain_q] = acc_new;
                    ovf_d[s1_chain_q] = (s1_bof_q ? 1'b0 : ovf_q[s1_chain_q]) | sat_any;
                    if (s1_eof_q) begin
                        valid_out_d = 1'b1;
                        eof_out_d   = 1'b1;
                        ovf_out_d   = ovf_d[s1_chain_q];
                        for (int unsigned i = 0; i < N; i++) vector_out_d[i] = DATA_WIDTH'(acc_new[i]);
                    end
                end
                default: begin
                    valid_out_d  = 1'b1;
                    bof_out_d    = s1_bof_q;
                    eof_out_d    = s1_eof_q;
                    vector_out_d = s1_vec_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q       <= INITIAL_MODE;
            axis_q       <= INITIAL_AXIS;
            bound_q      <= '0;
            cfg_cnt_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_vec_q     <= '0;
            s1_chain_q   <= '0;
            s1_mode_q    <= '0;
            s1_axis_q    <= 1'b0;
            s1_bof_q     <= 1'b0;
            s1_eof_q     <= 1'b0;
            acc_q        <= '0;
            ovf_q        <= '0;
            vector_out_q <= '0;
            chain_out_q  <= '0;
            valid_out_q  <= 1'b0;
            eof_out_q    <= 1'b0;
            bof_out_q    <= 1'b0;
            ovf_out_q    <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            axis_q       <= axis_d;
            bound_q      <= bound_d;
            cfg_cnt_q    <= cfg_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_vec_q     <= s1_vec_d;
            s1_chain_q   <= s1_chain_d;
            s1_mode_q    <= s1_mode_d;
            s1_axis_q    <= s1_axis_d;
            s1_bof_q     <= s1_bof_d;
            s1_eof_q     <= s1_eof_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            vector_out_q <= vector_out_d;
            chain_out_q  <= chain_out_d;
            valid_out_q  <= valid_out_d;
            eof_out_q    <= eof_out_d;
            bof_out_q    <= bof_out_d;
            ovf_out_q    <= ovf_out_d;
        end
    end

    assign bus.vector_out   = vector_out_q;
    assign bus.chainId_out  = chain_out_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.eof_out      = eof_out_q;
    assign bus.bof_out      = bof_out_q;
    assign bus.overflow_out = ovf_out_q;
endmodule
